// File: rtl/pci_initiator.sv
// PCI bus master: runs one memory read or write burst per local-side request,
// driving FRAME#/IRDY#/AD/C/BE# and reacting to TRDY#/DEVSEL#/STOP#.
module pci_initiator #(
    parameter int unsigned MAX_BURST      = 8,
    parameter int unsigned DEVSEL_TIMEOUT = 5
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        Frame,
    output logic        Irdy,
    input  logic        Trdy,
    input  logic        Devsel,
    input  logic        Stop,
    inout  wire  [31:0] Address,
    output logic [3:0]  Cbe,
    input  logic        Req,
    input  logic        Cmd_Wr,
    input  logic [31:0] Start_Addr,
    input  logic [3:0]  Burst_Len,
    input  logic [3:0]  Be,
    input  logic [31:0] Wr_Data,
    output logic        Wr_Ack,
    output logic [31:0] Rd_Data,
    output logic        Rd_Valid,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  Status
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam int unsigned WW = $clog2(DEVSEL_TIMEOUT + 1);
    localparam logic [3:0]  CMD_RD = 4'b0110;
    localparam logic [3:0]  CMD_WR = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_TURN,
        S_DATA,
        S_END
    } state_t;

    state_t        state;
    logic [31:0]   addr_q;
    logic          wr_q;
    logic [3:0]    be_q;
    logic [CW-1:0] count;
    logic [WW-1:0] wd;
    logic          dsel_seen;
    logic          ad_oe;
    logic          ad_wdata;

    logic [CW-1:0] burst_clip;
    logic          timeout_hit;
    logic          complete;
    logic          finish;
    logic [1:0]    fin_status;

    // Write data flows straight from the client so it tracks Wr_Ack-driven advances.
    assign Address = ad_oe ? (ad_wdata ? Wr_Data : addr_q) : {32{1'bz}};
    assign Wr_Ack  = (state == S_DATA) && wr_q && !Trdy && !timeout_hit;

    always_comb begin
        burst_clip = CW'(MAX_BURST);
        if (Burst_Len == 4'd0) begin
            burst_clip = CW'(1);
        end else if (32'(Burst_Len) <= MAX_BURST) begin
            burst_clip = CW'(Burst_Len);
        end
    end

    // Termination decision; the Devsel timeout outranks Stop, which outranks normal completion.
    always_comb begin
        timeout_hit = ((state == S_TURN) || (state == S_DATA)) && !dsel_seen && Devsel
                      && ((wd + WW'(1)) == WW'(DEVSEL_TIMEOUT));
        complete    = (state == S_DATA) && !Trdy && !timeout_hit;
        finish      = timeout_hit
                      || ((state == S_DATA) && (!Stop || (complete && (count == CW'(1)))));
        fin_status  = timeout_hit ? 2'b01 : (!Stop ? 2'b10 : 2'b00);
    end

    // Devsel watchdog: counts post-address clocks until the target claims the cycle.
    always_ff @(posedge Clk) begin
        if (!Rst || (state == S_ADDR)) begin
            wd        <= '0;
            dsel_seen <= 1'b0;
        end else if ((state == S_TURN) || (state == S_DATA)) begin
            if (!Devsel) begin
                dsel_seen <= 1'b1;
            end else if (!dsel_seen) begin
                wd <= wd + WW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= S_IDLE;
            Frame    <= 1'b1;
            Irdy     <= 1'b1;
            Cbe      <= 4'hF;
            ad_oe    <= 1'b0;
            ad_wdata <= 1'b0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            count    <= '0;
            Rd_Data  <= '0;
            Rd_Valid <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Status   <= 2'b00;
        end else begin
            Rd_Valid <= 1'b0;
            Done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Req) begin
                        addr_q   <= Start_Addr;
                        wr_q     <= Cmd_Wr;
                        be_q     <= Be;
                        count    <= burst_clip;
                        Status   <= 2'b00;
                        Frame    <= 1'b0;
                        Irdy     <= 1'b1;
                        Cbe      <= Cmd_Wr ? CMD_WR : CMD_RD;
                        ad_oe    <= 1'b1;
                        ad_wdata <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    Irdy     <= 1'b0;
                    Cbe      <= be_q;
                    Frame    <= (count == CW'(1));
                    ad_oe    <= wr_q;
                    ad_wdata <= wr_q;
                    state    <= wr_q ? S_DATA : S_TURN;
                end
                S_TURN, S_DATA: begin
                    if (complete) begin
                        count <= count - CW'(1);
                        Frame <= (count == CW'(2));
                        if (!wr_q) begin
                            Rd_Data  <= Address;
                            Rd_Valid <= 1'b1;
                        end
                    end
                    if (finish) begin
                        Status <= fin_status;
                        Frame  <= 1'b1;
                        Irdy   <= 1'b1;
                        Cbe    <= 4'hF;
                        ad_oe  <= 1'b0;
                        Done   <= 1'b1;
                        state  <= S_END;
                    end else if (state == S_TURN) begin
                        state <= S_DATA;
                    end
                end
                S_END: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
